// File: rtl/inv_sbox_decoder.sv
// Inverse S-box decoder: reads the forward table after start, builds inv[sbox[i]] = i, flags duplicates, then decodes pixels.
// Latency: build takes 1 + 2**DATA_W + RD_LAT cycles from start to inv_ready; pixel decode has 1-cycle latency.
// Backpressure: valid/ready; output register holds while pix_out_ready is low; input stalls unless the output slot frees.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start                         build request pulse
//   sbox_rd_en/addr/data          forward-table read port (data returns RD_LAT cycles after the strobe)
//   inv_ready, build_err          table built / duplicate forward value found (sticky until next build)
//   pix_in_valid/ready/data       encrypted pixel stream in
//   pix_out_valid/ready/data      inverse-substituted pixel stream out
module inv_sbox_decoder #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              sbox_rd_en,
    output logic [DATA_W-1:0] sbox_rd_addr,
    input  logic [DATA_W-1:0] sbox_rd_data,
    output logic              inv_ready,
    output logic              build_err,
    input  logic              pix_in_valid,
    output logic              pix_in_ready,
    input  logic [DATA_W-1:0] pix_in_data,
    output logic              pix_out_valid,
    input  logic              pix_out_ready,
    output logic [DATA_W-1:0] pix_out_data
);

    localparam int DEPTH = 2**DATA_W;
    localparam int PE_W  = DATA_W + 1;          // one pipe entry: {valid, addr}
    localparam int PW    = RD_LAT * PE_W;
    localparam logic [2:0] DRAIN_LAST = 3'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_READ,
        S_DRAIN,
        S_READY,
        S_ERROR
    } state_t;

    state_t              state_q;
    logic                rd_en_q;
    logic [DATA_W-1:0]   rd_addr_q;
    logic [PW-1:0]       pipe_q;                // newest entry in the low bits
    logic [DEPTH-1:0]    seen_q;
    logic                err_q;
    logic                build_err_q;
    logic                inv_ready_q;
    logic                defer_q;
    logic [2:0]          drain_cnt_q;
    logic                out_vld_q;
    logic [DATA_W-1:0]   out_dat_q;
    logic [DATA_W-1:0]   inv_mem [DEPTH];

    logic                ret_vld;
    logic [DATA_W-1:0]   ret_addr;
    logic                err_d;
    logic                in_acc;

    // The oldest pipe entry lines up with the data arriving this cycle.
    assign {ret_vld, ret_addr} = pipe_q[PW-1 -: PE_W];

    // Folds in a duplicate found on the very last return, so DRAIN decides on the complete picture.
    assign err_d = err_q | (ret_vld & seen_q[sbox_rd_data]);

    assign pix_in_ready = (state_q == S_READY) && !defer_q && (!out_vld_q || pix_out_ready);
    assign in_acc       = pix_in_valid && pix_in_ready;

    assign sbox_rd_en    = rd_en_q;
    assign sbox_rd_addr  = rd_addr_q;
    assign inv_ready     = inv_ready_q;
    assign build_err     = build_err_q;
    assign pix_out_valid = out_vld_q;
    assign pix_out_data  = out_dat_q;

    // Inverse table: plain storage, contents meaningless until a build completes.
    always_ff @(posedge clk) begin
        if (ret_vld) begin
            inv_mem[sbox_rd_data] <= ret_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            pipe_q      <= '0;
            seen_q      <= '0;
            err_q       <= 1'b0;
            build_err_q <= 1'b0;
            inv_ready_q <= 1'b0;
            defer_q     <= 1'b0;
            drain_cnt_q <= '0;
            out_vld_q   <= 1'b0;
            out_dat_q   <= '0;
        end else begin
            pipe_q <= (pipe_q << PE_W) | PW'({rd_en_q, rd_addr_q});

            if (ret_vld) begin
                seen_q[sbox_rd_data] <= 1'b1;
                err_q                <= err_d;
            end

            if (in_acc) begin
                out_vld_q <= 1'b1;
                out_dat_q <= inv_mem[pix_in_data];
            end else if (pix_out_ready) begin
                out_vld_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    seen_q      <= '0;
                    err_q       <= 1'b0;
                    build_err_q <= 1'b0;
                    rd_en_q     <= 1'b1;
                    rd_addr_q   <= '0;
                    state_q     <= S_READ;
                end
                S_READ: begin
                    // Address wraps back to 0 as the last read issues.
                    rd_addr_q <= rd_addr_q + 1'b1;
                    if (rd_addr_q == {DATA_W{1'b1}}) begin
                        rd_en_q     <= 1'b0;
                        drain_cnt_q <= '0;
                        state_q     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        if (err_d) begin
                            build_err_q <= 1'b1;
                            state_q     <= S_ERROR;
                        end else begin
                            inv_ready_q <= 1'b1;
                            state_q     <= S_READY;
                        end
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 3'd1;
                    end
                end
                S_READY: begin
                    if (defer_q) begin
                        // Rebuild only once the pending pixel has left the output register.
                        if (!out_vld_q || pix_out_ready) begin
                            defer_q <= 1'b0;
                            state_q <= S_CLEAR;
                        end
                    end else if (start) begin
                        inv_ready_q <= 1'b0;
                        if (out_vld_q) begin
                            defer_q <= 1'b1;
                        end else begin
                            state_q <= S_CLEAR;
                        end
                    end
                end
                S_ERROR: begin
                    if (start) begin
                        state_q <= S_CLEAR;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_sbox_decoder.sv
// Bench for inv_sbox_decoder: two instances (RD_LAT=1 and RD_LAT=3) fed from one forward-table model.
// Pixel traffic on the RD_LAT=1 instance is checked through an expected-value queue.
// The RD_LAT=3 instance covers the deferred-rebuild sequence.
module tb_inv_sbox_decoder;

    logic       clk;
    logic       rst;
    logic       start;
    logic       sbox_rd_en;
    logic [7:0] sbox_rd_addr;
    logic [7:0] sbox_rd_data;
    logic       inv_ready;
    logic       build_err;
    logic       pix_in_valid;
    logic       pix_in_ready;
    logic [7:0] pix_in_data;
    logic       pix_out_valid;
    logic       pix_out_ready;
    logic [7:0] pix_out_data;

    logic       start3;
    logic       rd_en3;
    logic [7:0] rd_addr3;
    logic [7:0] rd_data3;
    logic       inv_ready3;
    logic       build_err3;
    logic       p3_in_valid;
    logic       p3_in_ready;
    logic [7:0] p3_in_data;
    logic       p3_out_valid;
    logic       p3_out_ready;
    logic [7:0] p3_out_data;

    inv_sbox_decoder #(.DATA_W(8), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .sbox_rd_en(sbox_rd_en), .sbox_rd_addr(sbox_rd_addr), .sbox_rd_data(sbox_rd_data),
        .inv_ready(inv_ready), .build_err(build_err),
        .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready), .pix_in_data(pix_in_data),
        .pix_out_valid(pix_out_valid), .pix_out_ready(pix_out_ready), .pix_out_data(pix_out_data)
    );

    inv_sbox_decoder #(.DATA_W(8), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .sbox_rd_en(rd_en3), .sbox_rd_addr(rd_addr3), .sbox_rd_data(rd_data3),
        .inv_ready(inv_ready3), .build_err(build_err3),
        .pix_in_valid(p3_in_valid), .pix_in_ready(p3_in_ready), .pix_in_data(p3_in_data),
        .pix_out_valid(p3_out_valid), .pix_out_ready(p3_out_ready), .pix_out_data(p3_out_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Forward-table memory model, latency 1 and latency 3.
    logic [7:0] tb_sbox [256];
    logic [7:0] m3a, m3b;
    initial forever begin
        @(posedge clk);
        sbox_rd_data <= tb_sbox[sbox_rd_addr];
        m3a          <= tb_sbox[rd_addr3];
        m3b          <= m3a;
        rd_data3     <= m3b;
    end

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Scoreboard and output-stability monitor for the RD_LAT=1 instance.
    logic [7:0] exp_q [$];
    logic [7:0] pix_exp;
    int         out_cnt = 0;
    logic       held_v  = 1'b0;
    logic [7:0] held_d  = 8'h00;
    initial forever begin
        @(negedge clk);
        if (held_v && !rst) begin
            check("hold_valid", 32'(pix_out_valid), 32'd1);
            check("hold_data", 32'(pix_out_data), 32'(held_d));
        end
        held_v = pix_out_valid && !pix_out_ready && !rst;
        held_d = pix_out_data;
        if (pix_out_valid && pix_out_ready) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL sb_spurious: got output 0x%0h, expected no output", pix_out_data);
            end else begin
                check("sb_data", 32'(pix_out_data), 32'(exp_q.pop_front()));
                out_cnt++;
            end
        end
        if (pix_in_valid && pix_in_ready) exp_q.push_back(pix_exp);
    end

    // Read-strobe monitor: counts strobes, bursts, and addresses out of 0,1,2,... order.
    int         rd_cnt   = 0;
    int         spans    = 0;
    int         addr_bad = 0;
    logic       rd_prev  = 1'b0;
    logic [7:0] rd_last  = 8'h00;
    initial forever begin
        @(negedge clk);
        if (sbox_rd_en) begin
            rd_cnt++;
            if (!rd_prev) begin
                spans++;
                if (sbox_rd_addr != 8'h00) addr_bad++;
            end else if (sbox_rd_addr != 8'(rd_last + 8'd1)) begin
                addr_bad++;
            end
            rd_last = sbox_rd_addr;
        end
        rd_prev = sbox_rd_en;
    end

    int stalls = 0;

    // Entered and left at posedge+1; leaves pix_in_valid high for back-to-back sends.
    task automatic send(input logic [7:0] d, input logic [7:0] e);
        int w = 0;
        pix_in_valid = 1'b1;
        pix_in_data  = d;
        pix_exp      = e;
        @(negedge clk);
        while (!pix_in_ready && w < 60) begin
            @(posedge clk); #1;
            stalls++;
            w++;
            @(negedge clk);
        end
        if (!pix_in_ready) begin
            chk_cnt++;
            $display("FAIL send_timeout: pixel 0x%0h not accepted after %0d cycles, required < 60", d, w);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Returns edges counted after the edge that samples start.
    task automatic build(output int k);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while ((k < 2 || (!inv_ready && !build_err)) && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    typedef struct {
        logic [7:0] pix;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k, r0, s0, b0, o0, st0, w;
        logic [7:0] p;

        rst = 1'b1; start = 1'b0;
        pix_in_valid = 1'b0; pix_in_data = 8'h00; pix_exp = 8'h00; pix_out_ready = 1'b1;
        start3 = 1'b0; p3_in_valid = 1'b0; p3_in_data = 8'h00; p3_out_ready = 1'b1;
        for (int i = 0; i < 256; i++) tb_sbox[i] = 8'(i);

        // identity table entries, then sbox[i] = i ^ 0xA5 entries
        vecs[0] = '{8'h00, 8'h00};
        vecs[1] = '{8'h7F, 8'h7F};
        vecs[2] = '{8'hFF, 8'hFF};
        vecs[3] = '{8'h00, 8'hA5};
        vecs[4] = '{8'hA5, 8'h00};
        vecs[5] = '{8'h5A, 8'hFF};
        vecs[6] = '{8'hFF, 8'h5A};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_en", 32'(sbox_rd_en), 32'd0);
        check("rst_rd_addr", 32'(sbox_rd_addr), 32'd0);
        check("rst_inv_ready", 32'(inv_ready), 32'd0);
        check("rst_build_err", 32'(build_err), 32'd0);
        check("rst_in_ready", 32'(pix_in_ready), 32'd0);
        check("rst_out_valid", 32'(pix_out_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Identity build
        r0 = rd_cnt; s0 = spans; b0 = addr_bad;
        build(k);
        check("id_build_cycles", 32'(k), 32'd258);
        check("id_read_count", 32'(rd_cnt - r0), 32'd256);
        check("id_read_bursts", 32'(spans - s0), 32'd1);
        check("id_read_order", 32'(addr_bad - b0), 32'd0);
        check("id_inv_ready", 32'(inv_ready), 32'd1);
        check("id_build_err", 32'(build_err), 32'd0);
        for (int i = 0; i < 3; i++) send(vecs[i].pix, vecs[i].exp);
        pix_in_valid = 1'b0;
        wait_drain();

        // XOR table, vectors and a 1000-pixel stream
        for (int i = 0; i < 256; i++) tb_sbox[i] = 8'(i) ^ 8'hA5;
        build(k);
        check("xor_build_cycles", 32'(k), 32'd258);
        check("xor_inv_ready", 32'(inv_ready), 32'd1);
        for (int i = 3; i < 7; i++) send(vecs[i].pix, vecs[i].exp);
        pix_in_valid = 1'b0;
        wait_drain();
        o0 = out_cnt; st0 = stalls;
        repeat (1000) begin
            p = 8'($urandom_range(0, 255));
            send(p, p ^ 8'hA5);
        end
        pix_in_valid = 1'b0;
        wait_drain();
        check("stream_stalls", 32'(stalls - st0), 32'd0);
        check("stream_outputs", 32'(out_cnt - o0), 32'd1000);

        // Backpressure: ready toggles 1010..., then low for 5 cycles
        o0 = out_cnt;
        fork
            begin
                for (int i = 0; i < 20; i++) send(8'(i * 13), 8'(i * 13) ^ 8'hA5);
                pix_in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    pix_out_ready = ~i[0];
                    @(posedge clk); #1;
                end
                pix_out_ready = 1'b0;
                repeat (5) begin @(posedge clk); #1; end
                pix_out_ready = 1'b1;
            end
        join
        wait_drain();
        check("bp_outputs", 32'(out_cnt - o0), 32'd20);

        // Non-bijective table
        tb_sbox[17] = 8'h42;
        tb_sbox[3]  = 8'h42;
        build(k);
        check("err_build_cycles", 32'(k), 32'd258);
        check("err_build_err", 32'(build_err), 32'd1);
        check("err_inv_ready", 32'(inv_ready), 32'd0);
        pix_in_valid = 1'b1;
        pix_in_data  = 8'h10;
        @(negedge clk);
        check("err_in_ready", 32'(pix_in_ready), 32'd0);
        @(posedge clk); #1;
        pix_in_valid = 1'b0;

        // Rebuild with a valid table clears the error
        for (int i = 0; i < 256; i++) tb_sbox[i] = 8'(i);
        build(k);
        check("rebuild_cycles", 32'(k), 32'd258);
        check("rebuild_build_err", 32'(build_err), 32'd0);
        check("rebuild_inv_ready", 32'(inv_ready), 32'd1);
        for (int i = 0; i < 3; i++) send(vecs[i].pix, vecs[i].exp);
        pix_in_valid = 1'b0;
        wait_drain();

        // Reset in the middle of READ
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        @(negedge clk);
        while (!(sbox_rd_en && sbox_rd_addr == 8'd100) && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("midrst_reached_addr", 32'(sbox_rd_addr), 32'd100);
        rst = 1'b1;
        #1;
        check("midrst_rd_en", 32'(sbox_rd_en), 32'd0);
        check("midrst_rd_addr", 32'(sbox_rd_addr), 32'd0);
        check("midrst_inv_ready", 32'(inv_ready), 32'd0);
        check("midrst_out_valid", 32'(pix_out_valid), 32'd0);
        check("midrst_in_ready", 32'(pix_in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        r0 = rd_cnt;
        repeat (5) begin @(posedge clk); #1; end
        check("postrst_inv_ready", 32'(inv_ready), 32'd0);
        check("postrst_no_reads", 32'(rd_cnt - r0), 32'd0);
        r0 = rd_cnt; s0 = spans; b0 = addr_bad;
        build(k);
        check("postrst_build_cycles", 32'(k), 32'd258);
        check("postrst_read_count", 32'(rd_cnt - r0), 32'd256);
        check("postrst_read_bursts", 32'(spans - s0), 32'd1);
        check("postrst_read_order", 32'(addr_bad - b0), 32'd0);

        // RD_LAT=3 instance: build, then start while an output is stalled
        for (int i = 0; i < 256; i++) tb_sbox[i] = 8'(i) ^ 8'hA5;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        k = 0;
        while (!inv_ready3 && k < 400) begin @(posedge clk); #1; k++; end
        check("lat3_build_cycles", 32'(k), 32'd260);
        p3_out_ready = 1'b0;
        p3_in_valid  = 1'b1;
        p3_in_data   = 8'h00;
        @(negedge clk);
        check("lat3_in_ready", 32'(p3_in_ready), 32'd1);
        @(posedge clk); #1;
        p3_in_valid = 1'b0;
        check("lat3_out_valid", 32'(p3_out_valid), 32'd1);
        check("lat3_out_data", 32'(p3_out_data), 32'hA5);
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        check("defer_inv_ready", 32'(inv_ready3), 32'd0);
        check("defer_in_ready", 32'(p3_in_ready), 32'd0);
        check("defer_out_valid", 32'(p3_out_valid), 32'd1);
        check("defer_out_data", 32'(p3_out_data), 32'hA5);
        repeat (2) begin
            @(posedge clk); #1;
            check("defer_hold_data", 32'(p3_out_data), 32'hA5);
            check("defer_no_read", 32'(rd_en3), 32'd0);
        end
        p3_out_ready = 1'b1;
        @(negedge clk);
        check("defer_deliver_valid", 32'(p3_out_valid), 32'd1);
        check("defer_deliver_data", 32'(p3_out_data), 32'hA5);
        @(posedge clk); #1;
        check("defer_out_cleared", 32'(p3_out_valid), 32'd0);
        k = 0;
        while (!inv_ready3 && k < 400) begin @(posedge clk); #1; k++; end
        check("defer_rebuild_cycles", 32'(k), 32'd260);
        check("defer_rebuild_err", 32'(build_err3), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
